// File: rtl/pe_feeder.sv
// pe_feeder: streams NUM_TAPS (weight, inmap) pairs into one pe, captures each result on the
// rising edge of outmap_vld and accumulates the signed outraw values into a guarded running sum.
//   state | meaning
//   IDLE  | no job, buffers writable, waiting for start
//   ISSUE | first cycle of a tap, pair presented to the pe
//   WAIT  | pair held, waiting for outmap_vld rising edge or timeout
//   DONE  | job finished, results held, buffers writable
module pe_feeder #(
  parameter int DATA_SIZE = 8,
  parameter int HW_WIDTH  = 16,
  parameter int NUM_TAPS  = 9,
  parameter int TIMEOUT   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [3:0]            wr_addr,
  input  logic [DATA_SIZE-1:0]  wr_data,
  input  logic [DATA_SIZE-1:0]  bias_in,
  input  logic                  start,
  output logic [DATA_SIZE-1:0]  weight,
  output logic [DATA_SIZE-1:0]  inmap,
  output logic                  weight_vld,
  output logic                  inmap_vld,
  output logic [DATA_SIZE-1:0]  bias,
  input  logic [DATA_SIZE-1:0]  outmap,
  input  logic                  outmap_vld,
  input  logic [HW_WIDTH-1:0]   outraw,
  output logic [DATA_SIZE-1:0]  res_data,
  output logic                  res_vld,
  output logic [HW_WIDTH+3:0]   acc_sum,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int ACC_W = HW_WIDTH + 4;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            tap_q, tap_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vld_prev_q, vld_prev_d;
  logic [DATA_SIZE-1:0]  bias_q, bias_d;
  logic [DATA_SIZE-1:0]  res_data_q, res_data_d;
  logic                  res_vld_q, res_vld_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_SIZE-1:0]  wbuf_q [NUM_TAPS];
  logic [DATA_SIZE-1:0]  wbuf_d [NUM_TAPS];
  logic [DATA_SIZE-1:0]  ibuf_q [NUM_TAPS];
  logic [DATA_SIZE-1:0]  ibuf_d [NUM_TAPS];

  logic idle_like;
  logic vld_edge;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign vld_edge  = outmap_vld && !vld_prev_q;

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    cnt_d      = cnt_q;
    bias_d     = bias_q;
    res_data_d = res_data_q;
    acc_d      = acc_q;
    err_d      = err_q;
    res_vld_d  = 1'b0;
    done_d     = (state_q == S_DONE) && res_vld_q;
    vld_prev_d = outmap_vld;
    wbuf_d     = wbuf_q;
    ibuf_d     = ibuf_q;

    // the write lands in the same edge as start, so ISSUE already sees it
    if (idle_like && wr_en && (int'(wr_addr) < NUM_TAPS)) begin
      if (wr_sel) ibuf_d[wr_addr] = wr_data;
      else        wbuf_d[wr_addr] = wr_data;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ISSUE;
          tap_d   = 4'd0;
          acc_d   = '0;
          err_d   = 1'b0;
          bias_d  = bias_in;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(TIMEOUT - 1);
      end
      S_WAIT: begin
        if (vld_edge) begin
          res_data_d = outmap;
          res_vld_d  = 1'b1;
          acc_d      = acc_q + {{4{outraw[HW_WIDTH-1]}}, outraw};
          if (tap_q == 4'(NUM_TAPS - 1)) begin
            state_d = S_DONE;
          end else begin
            tap_d   = tap_q + 4'd1;
            state_d = S_ISSUE;
          end
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tap_q      <= 4'd0;
      cnt_q      <= '0;
      vld_prev_q <= 1'b0;
      bias_q     <= '0;
      res_data_q <= '0;
      res_vld_q  <= 1'b0;
      acc_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      cnt_q      <= cnt_d;
      vld_prev_q <= vld_prev_d;
      bias_q     <= bias_d;
      res_data_q <= res_data_d;
      res_vld_q  <= res_vld_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // buffer contents carry no reset value
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
    ibuf_q <= ibuf_d;
  end

  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign weight     = busy ? wbuf_q[tap_q] : '0;
  assign inmap      = busy ? ibuf_q[tap_q] : '0;
  assign weight_vld = busy;
  assign inmap_vld  = busy;
  assign bias       = bias_q;
  assign res_data   = res_data_q;
  assign res_vld    = res_vld_q;
  assign acc_sum    = acc_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: a pe model answers each issued pair, and a job-level reference model
// predicts every captured result, the running sum, done timing, timeout and reset behaviour.
module tb_pe_feeder;
  localparam int DS = 8;
  localparam int HW = 16;
  localparam int NT = 9;
  localparam int TO = 64;
  localparam int AW = HW + 4;

  logic clk = 1'b0;
  logic rst, wr_en, wr_sel, start;
  logic [3:0] wr_addr;
  logic [DS-1:0] wr_data, bias_in;
  logic [DS-1:0] weight, inmap, bias, outmap, res_data;
  logic weight_vld, inmap_vld, outmap_vld, res_vld, busy, done, err;
  logic [HW-1:0] outraw;
  logic [AW-1:0] acc_sum;
  logic [57:0] all_outs;

  int errors = 0;
  int checks = 0;
  logic [DS-1:0] wm [NT];
  logic [DS-1:0] xm [NT];
  logic [DS-1:0] bm;

  pe_feeder #(.DATA_SIZE(DS), .HW_WIDTH(HW), .NUM_TAPS(NT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .bias_in(bias_in), .start(start), .weight(weight), .inmap(inmap),
    .weight_vld(weight_vld), .inmap_vld(inmap_vld), .bias(bias), .outmap(outmap),
    .outmap_vld(outmap_vld), .outraw(outraw), .res_data(res_data), .res_vld(res_vld),
    .acc_sum(acc_sum), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign all_outs = {weight, inmap, weight_vld, inmap_vld, bias, res_data, res_vld,
                     acc_sum, busy, done, err};

  // pe arithmetic: Q4.3 * Q4.3 gives Q9.6, bias aligned by 3 extra fraction bits
  function automatic int pe_raw(input logic [DS-1:0] w, input logic [DS-1:0] x,
                                input logic [DS-1:0] b);
    return int'($signed(w)) * int'($signed(x)) + int'($signed(b)) * 8;
  endfunction

  function automatic logic [DS-1:0] pe_map(input int raw);
    int s;
    s = raw >>> 3;
    return s[DS-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [3:0] a, input logic [DS-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int k = 0; k < NT; k++) begin
      wr(1'b0, 4'(k), wm[k]);
      wr(1'b1, 4'(k), xm[k]);
    end
    wr(1'b0, 4'd9, 8'hAA);
    wr(1'b1, 4'd15, 8'h55);
  endtask

  task automatic randomize_job();
    for (int k = 0; k < NT; k++) begin
      wm[k] = 8'($urandom);
      xm[k] = 8'($urandom);
    end
    bm = 8'($urandom);
  endtask

  // mode 0 normal, 1 outmap_vld held high at start, 2 start/wr_en while busy,
  // 3 rst at tap 4, 4 buffer write in the start cycle
  task automatic run_job(input int mode);
    int k_issue, k_res, n_done, cyc, last_res, hold, dly, exp_acc, exp_hold, r;
    bit prev_wv, pe_vld, fin;
    logic [DS-1:0] exp_map;
    k_issue = 0; k_res = 0; n_done = 0; cyc = 0; last_res = -10; dly = 0; exp_acc = 0;
    prev_wv = 1'b0; fin = 1'b0;
    hold = (mode == 1) ? 5 : 0;
    pe_vld = (mode == 1);
    outmap_vld = pe_vld; outraw = 16'h7FFF; outmap = 8'h7F;
    bias_in = bm; start = 1'b1;
    if (mode == 4) begin
      wm[0] = 8'($urandom);
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = wm[0];
    end
    tick();
    start = 1'b0; wr_en = 1'b0; bias_in = ~bm;
    checks++;
    if (err !== 1'b0 || bias !== bm || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_accept mode=%0d: err=%b bias=%h busy=%b, want err=0 bias=%h busy=1",
               mode, err, bias, busy, bm);
    end
    while (!fin && cyc < 2000) begin
      if (res_vld) begin
        checks++;
        if (k_res >= k_issue) begin
          errors++;
          $display("FAIL spurious_capture mode=%0d: res_vld with %0d captured, %0d issued",
                   mode, k_res, k_issue);
        end else begin
          r = pe_raw(wm[k_res], xm[k_res], bm);
          exp_acc += r;
          exp_map = pe_map(r);
          if (acc_sum !== AW'(exp_acc) || res_data !== exp_map) begin
            errors++;
            $display("FAIL tap_result mode=%0d tap=%0d: acc=%h res=%h, want acc=%h res=%h",
                     mode, k_res, acc_sum, res_data, AW'(exp_acc), exp_map);
          end
          k_res++;
          last_res = cyc;
        end
      end
      if (done) begin
        n_done++;
        checks++;
        if (cyc != last_res + 1 || k_res != NT) begin
          errors++;
          $display("FAIL done_timing mode=%0d: done at cyc %0d after %0d results, want cyc %0d after %0d",
                   mode, cyc, k_res, last_res + 1, NT);
        end
        fin = 1'b1;
      end
      if (rst) begin
        checks++;
        if (all_outs !== '0) begin
          errors++;
          $display("FAIL reset_midjob: outputs=%h, want 0", all_outs);
        end
        rst = 1'b0;
        fin = 1'b1;
      end else if (mode == 3 && k_res == 4) begin
        rst = 1'b1;
      end
      if (mode == 2 && cyc == 10) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL inject_busy: busy=%b want 1", busy);
        end
        start = 1'b1; bias_in = ~bm;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd8; wr_data = ~wm[8];
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) pe_vld = 1'b0;
      end else if (pe_vld) begin
        pe_vld = 1'b0;
        dly = $urandom_range(0, 3);
      end else if (weight_vld && prev_wv && k_issue < NT) begin
        if (dly > 0) begin
          dly--;
        end else begin
          checks++;
          if (weight !== wm[k_issue] || inmap !== xm[k_issue] || inmap_vld !== 1'b1) begin
            errors++;
            $display("FAIL pair_order mode=%0d tap=%0d: w=%h x=%h xv=%b, want w=%h x=%h xv=1",
                     mode, k_issue, weight, inmap, inmap_vld, wm[k_issue], xm[k_issue]);
          end
          r = pe_raw(weight, inmap, bias);
          outraw = r[HW-1:0];
          outmap = pe_map(r);
          pe_vld = 1'b1;
          k_issue++;
        end
      end
      prev_wv = weight_vld;
      outmap_vld = pe_vld;
      tick();
      cyc++;
    end
    start = 1'b0; wr_en = 1'b0; rst = 1'b0; outmap_vld = 1'b0;
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL job_bound mode=%0d: job did not finish, %0d results", mode, k_res);
    end
    exp_hold = (mode == 3) ? 0 : exp_acc;
    if (mode != 3) begin
      checks++;
      if (k_res != NT || n_done != 1 || acc_sum !== AW'(exp_acc)) begin
        errors++;
        $display("FAIL job_summary mode=%0d: results=%0d dones=%0d acc=%h, want %0d 1 %h",
                 mode, k_res, n_done, acc_sum, NT, AW'(exp_acc));
      end
    end
    repeat (3) begin
      tick();
      checks++;
      if (done !== 1'b0 || res_vld !== 1'b0 || busy !== 1'b0 || acc_sum !== AW'(exp_hold)) begin
        errors++;
        $display("FAIL post_job mode=%0d: done=%b res_vld=%b busy=%b acc=%h, want 0 0 0 %h",
                 mode, done, res_vld, busy, acc_sum, AW'(exp_hold));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = '0;
    bias_in = '0; start = 1'b0; outmap = '0; outmap_vld = 1'b0; outraw = '0;
    repeat (3) tick();
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: outputs=%h, want 0", all_outs);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || weight_vld !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b err=%b wvld=%b, want 0", busy, err, weight_vld);
    end
  endtask

  task automatic test_single();
    randomize_job();
    wm[0] = 8'h05; xm[0] = 8'h03; bm = 8'h02;
    load_all();
    run_job(0);
  endtask

  task automatic test_mixed_signs();
    randomize_job();
    wm[3] = 8'h83; xm[3] = 8'h02;
    wm[5] = 8'h80; xm[5] = 8'h80;
    load_all();
    run_job(0);
  endtask

  task automatic test_vld_held();
    run_job(1);
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    outmap_vld = 1'b0; bias_in = bm; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= TO + 1; i++) begin
      if (res_vld || done) bad++;
      if (i == TO) begin
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || weight_vld !== 1'b1) begin
          errors++;
          $display("FAIL timeout_early: busy=%b err=%b wvld=%b, want 1 0 1", busy, err, weight_vld);
        end
      end
      if (i == TO + 1) begin
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || weight_vld !== 1'b0 || inmap_vld !== 1'b0) begin
          errors++;
          $display("FAIL timeout_abort: err=%b busy=%b wvld=%b xvld=%b, want 1 0 0 0",
                   err, busy, weight_vld, inmap_vld);
        end
      end
      if (i <= TO) tick();
    end
    repeat (2) tick();
    checks++;
    if (err !== 1'b1 || bad != 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b pulses=%0d, want err=1 pulses=0", err, bad);
    end
  endtask

  task automatic test_ignore_busy();
    randomize_job();
    load_all();
    run_job(2);
    run_job(0);
  endtask

  task automatic test_rst_midjob();
    run_job(3);
    randomize_job();
    load_all();
    run_job(0);
  endtask

  task automatic test_back_to_back();
    run_job(4);
    run_job(0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_mixed_signs();
    test_vld_held();
    test_timeout();
    test_ignore_busy();
    test_rst_midjob();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
